wdog_write_ctrl: RTL and testbench
==================================

// Module: wdog_write_ctrl
// PURPOSE
//  Write-side counterpart of the watchdog register block: decodes bus writes (WRITE/ADDR/WDATA)
//  into control, interval and kick registers and runs the watchdog countdown FSM.
//  Produces Status_Register / Interval_valid for the read-decode mux, plus an early-warning IRQ
//  and a sticky watchdog reset request to the system reset controller.
// PARAMETERS
//  CNT_W       32             counter / interval width (bits)
//  WARN_TICKS  16             ticks spent in WARN before expiry; must be >= 1
//  KICK_KEY    32'h0000_0055  WDATA value required for a valid kick write
// PORTS
//  CLK             in   1      single system clock, all logic rising-edge
//  RESET           in   1      synchronous, active-high reset
//  WRITE           in   1      bus write strobe, one write per cycle
//  ADDR            in   4      register address
//  WDATA           in   32     write data
//  KICK            in   1      external kick pulse (hardware pin, already synchronised to CLK)
//  Wdog_Timer_CLK  in   1      timebase tick; single-cycle enable in CLK domain, not a clock
//  Status_Register out  1      1 when FSM != IDLE
//  Interval_valid  out  1      1 when a non-zero interval is loaded
//  COUNT           out  CNT_W  current countdown value
//  WDOG_IRQ        out  1      high while in WARN
//  WDOG_RST        out  1      high in EXPIRED, sticky until RESET
//  WR_ERR          out  1      sticky error flag, cleared by writing 1 to CTRL[2]
// BEHAVIOUR
//  Reset: all outputs 0, INTERVAL=0, FSM=IDLE. All outputs registered; writes act on next edge.
//  Write map (WRITE=1):
//   0x0 CTRL: bit0=enable, bit1=disable, bit2=clear WR_ERR. bit0 and bit1 both set -> disable wins.
//       enable: only from IDLE with Interval_valid=1 -> COUNT<=INTERVAL, go RUN; else WR_ERR<=1.
//   0x1 INTERVAL: IDLE only -> INTERVAL<=WDATA, Interval_valid<=(WDATA!=0); else ignored, WR_ERR<=1.
//   0x2 KICK: WDATA==KICK_KEY acts as kick; any other value ignored, WR_ERR<=1.
//   0x3..0xF: writes ignored, no error.
//  Kick (pin KICK or valid 0x2 write): RUN/WARN -> COUNT<=INTERVAL, WDOG_IRQ<=0, go RUN.
//   Ignored (no error) in IDLE and EXPIRED.
//  FSM:
//   IDLE -> RUN    on valid enable.
//   RUN            on tick: COUNT==1 -> COUNT<=WARN_TICKS, go WARN; else COUNT<=COUNT-1.
//   WARN           on tick: COUNT==1 -> COUNT<=0, go EXPIRED; else decrement.
//   EXPIRED        WDOG_RST=1; disable and kick ignored; exit only via RESET.
//   RUN/WARN -> IDLE on disable: COUNT<=0, IRQ<=0.
//  Timing: expiry of a loaded interval N occurs exactly N ticks after load/kick;
//   WDOG_RST rises exactly WARN_TICKS ticks after entering WARN.
//  Same-cycle priority: RESET > disable > kick > tick. Kick + tick -> reload, no decrement.
//   Disable write + KICK pin -> IDLE.
//  Width: decrement is unsigned; COUNT never wraps (0 is only reached by entering EXPIRED or IDLE).
//  RESET mid-operation: returns to IDLE, clears INTERVAL/Interval_valid. The timer must be re-armed.
// STRUCTURE
//  Shared package wdog_pkg: address constants (ADDR_CTRL=0, ADDR_INTERVAL=1, ADDR_KICK=2),
//   CTRL bit indices, FSM state encoding (IDLE/RUN/WARN/EXPIRED), default KICK_KEY;
//   also used by the read decoder.
//  One sub-module, wdog_down_counter: load/reload, tick-enabled decrement, ==1 detect.
//   Write decode and FSM stay in this top module.
// TESTING
//  1. INTERVAL=5, enable, 5 ticks -> WDOG_IRQ=1 after tick 5, COUNT=WARN_TICKS;
//     WARN_TICKS further ticks -> WDOG_RST=1 and stays 1 until RESET.
//  2. INTERVAL=5, enable, 3 ticks, write 0x2=0x55 -> COUNT=5, still RUN; IRQ never asserts.
//  3. Write 0x2=0x54 while RUN -> WR_ERR=1, COUNT unchanged; CTRL=0x4 -> WR_ERR=0.
//  4. Enable with INTERVAL=0 -> stays IDLE, WR_ERR=1.
//     Write INTERVAL while RUN -> value unchanged, WR_ERR=1.
//  5. Same cycle: KICK pin + tick with COUNT=1 -> COUNT=INTERVAL, no WARN.
//     CTRL=0x3 while WARN -> IDLE, IRQ=0.
//  6. RESET asserted in WARN and in EXPIRED -> next cycle all outputs 0, Interval_valid=0.

Source files
------------

// File: rtl/wdog_pkg.sv
// Shared watchdog definitions: register addresses, CTRL bit positions,
// FSM state encoding and the default kick key. Also used by the read decoder.
package wdog_pkg;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 32;

   localparam logic [ADDR_W-1:0] ADDR_CTRL     = 4'h0;
   localparam logic [ADDR_W-1:0] ADDR_INTERVAL = 4'h1;
   localparam logic [ADDR_W-1:0] ADDR_KICK     = 4'h2;

   localparam int CTRL_EN_BIT  = 0;
   localparam int CTRL_DIS_BIT = 1;
   localparam int CTRL_CLR_BIT = 2;

   localparam logic [DATA_W-1:0] KICK_KEY_DEFAULT = 32'h0000_0055;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_WARN    = 2'd2,
      ST_EXPIRED = 2'd3
   } wdog_state_e;

endpackage

// File: rtl/wdog_write_ctrl_if.sv
// Register-write bus into the watchdog: one write per cycle, strobe plus address/data.
interface wdog_write_ctrl_if;
   import wdog_pkg::*;

   logic              WRITE;
   logic [ADDR_W-1:0] ADDR;
   logic [DATA_W-1:0] WDATA;

   modport master (output WRITE, output ADDR, output WDATA);
   modport slave  (input  WRITE, input  ADDR, input  WDATA);

endinterface

// File: rtl/wdog_down_counter.sv
// Watchdog countdown register: clear, load and tick-enabled decrement,
// with a "count is one" flag so the FSM can act on the last tick.
module wdog_down_counter #(
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             clear,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic [CNT_W-1:0] count,
   output logic             is_one
);

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Counter register: clear beats load beats decrement; zero never wraps
   always_ff @(posedge CLK) begin
      if (RESET) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - ONE;
      end
   end

   assign is_one = (count == ONE);

endmodule

// File: rtl/wdog_write_ctrl.sv
// Watchdog write side: decodes CTRL/INTERVAL/KICK writes, runs the
// IDLE/RUN/WARN/EXPIRED countdown FSM and drives status, IRQ and reset request.
module wdog_write_ctrl
   import wdog_pkg::*;
#(
   parameter int                CNT_W      = 32,
   parameter int                WARN_TICKS = 16,
   parameter logic [DATA_W-1:0] KICK_KEY   = KICK_KEY_DEFAULT
) (
   input  logic               CLK,
   input  logic               RESET,
   wdog_write_ctrl_if.slave   bus,
   input  logic               KICK,
   input  logic               Wdog_Timer_CLK,
   output logic               Status_Register,
   output logic               Interval_valid,
   output logic [CNT_W-1:0]   COUNT,
   output logic               WDOG_IRQ,
   output logic               WDOG_RST,
   output logic               WR_ERR
);

   wdog_state_e state, next_state;

   logic [CNT_W-1:0] interval;
   logic             wr_ctrl, wr_interval, wr_kick;
   logic             en_req, dis_req, clr_req, key_ok, kick_req;
   logic             err_set;
   logic             cnt_clear, cnt_load, cnt_dec, cnt_is_one;
   logic [CNT_W-1:0] cnt_load_val;
   logic             next_status, next_irq, next_rst;

   // Write decode; a disable in the same CTRL write suppresses the enable
   always_comb begin
      wr_ctrl     = bus.WRITE && (bus.ADDR == ADDR_CTRL);
      wr_interval = bus.WRITE && (bus.ADDR == ADDR_INTERVAL);
      wr_kick     = bus.WRITE && (bus.ADDR == ADDR_KICK);
      dis_req     = wr_ctrl && bus.WDATA[CTRL_DIS_BIT];
      en_req      = wr_ctrl && bus.WDATA[CTRL_EN_BIT] && !bus.WDATA[CTRL_DIS_BIT];
      clr_req     = wr_ctrl && bus.WDATA[CTRL_CLR_BIT];
      key_ok      = (bus.WDATA == KICK_KEY);
      kick_req    = KICK || (wr_kick && key_ok);
      err_set     = (en_req && !((state == ST_IDLE) && Interval_valid))
                 || (wr_interval && (state != ST_IDLE))
                 || (wr_kick && !key_ok);
   end

   // Interval register and its valid flag, only writable while idle
   always_ff @(posedge CLK) begin
      if (RESET) begin
         interval       <= '0;
         Interval_valid <= 1'b0;
      end else if (wr_interval && (state == ST_IDLE)) begin
         interval       <= CNT_W'(bus.WDATA);
         Interval_valid <= (CNT_W'(bus.WDATA) != '0);
      end
   end

   // Sticky write-error flag; a new error in the same cycle outranks the clear
   always_ff @(posedge CLK) begin
      if (RESET) begin
         WR_ERR <= 1'b0;
      end else if (err_set) begin
         WR_ERR <= 1'b1;
      end else if (clr_req) begin
         WR_ERR <= 1'b0;
      end
   end

   // FSM state register
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and counter control: disable > kick > tick
   always_comb begin
      next_state   = state;
      cnt_clear    = 1'b0;
      cnt_load     = 1'b0;
      cnt_load_val = interval;
      cnt_dec      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (en_req && Interval_valid) begin
               cnt_load   = 1'b1;
               next_state = ST_RUN;
            end
         end
         ST_RUN, ST_WARN: begin
            if (dis_req) begin
               cnt_clear  = 1'b1;
               next_state = ST_IDLE;
            end else if (kick_req) begin
               cnt_load   = 1'b1;
               next_state = ST_RUN;
            end else if (Wdog_Timer_CLK) begin
               if (cnt_is_one) begin
                  if (state == ST_RUN) begin
                     cnt_load     = 1'b1;
                     cnt_load_val = CNT_W'(WARN_TICKS);
                     next_state   = ST_WARN;
                  end else begin
                     cnt_clear  = 1'b1;
                     next_state = ST_EXPIRED;
                  end
               end else begin
                  cnt_dec = 1'b1;
               end
            end
         end
         ST_EXPIRED: begin
            next_state = ST_EXPIRED;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // Output decode from the upcoming state so the flops below track the FSM exactly
   always_comb begin
      next_status = (next_state != ST_IDLE);
      next_irq    = (next_state == ST_WARN);
      next_rst    = (next_state == ST_EXPIRED);
   end

   // Registered status, IRQ and reset-request outputs
   always_ff @(posedge CLK) begin
      if (RESET) begin
         Status_Register <= 1'b0;
         WDOG_IRQ        <= 1'b0;
         WDOG_RST        <= 1'b0;
      end else begin
         Status_Register <= next_status;
         WDOG_IRQ        <= next_irq;
         WDOG_RST        <= next_rst;
      end
   end

   wdog_down_counter #(
      .CNT_W (CNT_W)
   ) u_counter (
      .CLK      (CLK),
      .RESET    (RESET),
      .clear    (cnt_clear),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .dec      (cnt_dec),
      .count    (COUNT),
      .is_one   (cnt_is_one)
   );

endmodule

// File: tb/tb_wdog_write_ctrl.sv
// Directed testbench for wdog_write_ctrl with hand-computed expectations.
module tb_wdog_write_ctrl;
   import wdog_pkg::*;

   localparam int CNT_W      = 32;
   localparam int WARN_TICKS = 16;

   logic             CLK;
   logic             RESET;
   logic             KICK;
   logic             Wdog_Timer_CLK;
   logic             Status_Register;
   logic             Interval_valid;
   logic [CNT_W-1:0] COUNT;
   logic             WDOG_IRQ;
   logic             WDOG_RST;
   logic             WR_ERR;

   int compares;
   int mismatches;

   wdog_write_ctrl_if bus_if ();

   wdog_write_ctrl #(
      .CNT_W      (CNT_W),
      .WARN_TICKS (WARN_TICKS),
      .KICK_KEY   (32'h0000_0055)
   ) dut (
      .CLK             (CLK),
      .RESET           (RESET),
      .bus             (bus_if.slave),
      .KICK            (KICK),
      .Wdog_Timer_CLK  (Wdog_Timer_CLK),
      .Status_Register (Status_Register),
      .Interval_valid  (Interval_valid),
      .COUNT           (COUNT),
      .WDOG_IRQ        (WDOG_IRQ),
      .WDOG_RST        (WDOG_RST),
      .WR_ERR          (WR_ERR)
   );

   // Free-running 10 ns system clock
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Count one comparison and report it if it disagrees
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compares++;
      if (observed !== expected) begin
         mismatches++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Compare every DUT output against one expected snapshot
   task automatic expectState(input string tag, input logic st, input logic iv,
                              input logic [31:0] cnt, input logic irq,
                              input logic rst, input logic err);
      checkOutput({tag, ".status"}, {31'd0, Status_Register}, {31'd0, st});
      checkOutput({tag, ".ivalid"}, {31'd0, Interval_valid}, {31'd0, iv});
      checkOutput({tag, ".count"},  COUNT, cnt);
      checkOutput({tag, ".irq"},    {31'd0, WDOG_IRQ}, {31'd0, irq});
      checkOutput({tag, ".rst"},    {31'd0, WDOG_RST}, {31'd0, rst});
      checkOutput({tag, ".err"},    {31'd0, WR_ERR}, {31'd0, err});
   endtask

   // Drive one cycle of inputs at the falling edge, release them just after the rising edge
   task automatic applyStimulus(input logic wr, input logic [3:0] addr,
                                input logic [31:0] data, input logic kick,
                                input logic tick);
      @(negedge CLK);
      bus_if.WRITE   = wr;
      bus_if.ADDR    = addr;
      bus_if.WDATA   = data;
      KICK           = kick;
      Wdog_Timer_CLK = tick;
      @(posedge CLK);
      #1;
      bus_if.WRITE   = 1'b0;
      bus_if.ADDR    = 4'h0;
      bus_if.WDATA   = 32'h0;
      KICK           = 1'b0;
      Wdog_Timer_CLK = 1'b0;
   endtask

   task automatic busWrite(input logic [3:0] addr, input logic [31:0] data);
      applyStimulus(1'b1, addr, data, 1'b0, 1'b0);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'h0, 32'h0, 1'b0, 1'b1);
   endtask

   task automatic pulseReset();
      @(negedge CLK);
      RESET = 1'b1;
      @(posedge CLK);
      #1;
      RESET = 1'b0;
   endtask

   // Directed scenarios
   initial begin
      compares       = 0;
      mismatches     = 0;
      RESET          = 1'b1;
      KICK           = 1'b0;
      Wdog_Timer_CLK = 1'b0;
      bus_if.WRITE   = 1'b0;
      bus_if.ADDR    = 4'h0;
      bus_if.WDATA   = 32'h0;
      repeat (2) @(posedge CLK);
      #1;
      expectState("reset", 0, 0, 0, 0, 0, 0);
      @(negedge CLK);
      RESET = 1'b0;

      $display("[TB] expiry path");
      busWrite(ADDR_INTERVAL, 32'd5);
      expectState("t1.load", 0, 1, 0, 0, 0, 0);
      busWrite(ADDR_CTRL, 32'h1);
      expectState("t1.enable", 1, 1, 5, 0, 0, 0);
      ticks(4);
      expectState("t1.tick4", 1, 1, 1, 0, 0, 0);
      ticks(1);
      expectState("t1.warn", 1, 1, WARN_TICKS, 1, 0, 0);
      ticks(WARN_TICKS - 1);
      expectState("t1.warnlast", 1, 1, 1, 1, 0, 0);
      ticks(1);
      expectState("t1.expired", 1, 1, 0, 0, 1, 0);
      busWrite(ADDR_CTRL, 32'h2);
      applyStimulus(1'b0, 4'h0, 32'h0, 1'b1, 1'b1);
      ticks(3);
      expectState("t1.sticky", 1, 1, 0, 0, 1, 0);
      pulseReset();
      expectState("t1.reset", 0, 0, 0, 0, 0, 0);

      $display("[TB] kick write and write errors");
      busWrite(ADDR_INTERVAL, 32'd5);
      busWrite(ADDR_CTRL, 32'h1);
      ticks(3);
      expectState("t2.tick3", 1, 1, 2, 0, 0, 0);
      busWrite(ADDR_KICK, 32'h55);
      expectState("t2.kick", 1, 1, 5, 0, 0, 0);
      ticks(4);
      expectState("t2.tick4", 1, 1, 1, 0, 0, 0);
      busWrite(ADDR_KICK, 32'h54);
      expectState("t3.badkey", 1, 1, 1, 0, 0, 1);
      busWrite(ADDR_CTRL, 32'h4);
      expectState("t3.clear", 1, 1, 1, 0, 0, 0);
      busWrite(ADDR_INTERVAL, 32'd9);
      expectState("t4.intrun", 1, 1, 1, 0, 0, 1);

      $display("[TB] same-cycle priority");
      applyStimulus(1'b0, 4'h0, 32'h0, 1'b1, 1'b1);
      expectState("t5.kicktick", 1, 1, 5, 0, 0, 1);
      busWrite(ADDR_CTRL, 32'h4);
      ticks(5);
      expectState("t5.warn", 1, 1, WARN_TICKS, 1, 0, 0);
      busWrite(ADDR_CTRL, 32'h3);
      expectState("t5.disable", 0, 1, 0, 0, 0, 0);
      busWrite(ADDR_INTERVAL, 32'd0);
      expectState("t4.zeroint", 0, 0, 0, 0, 0, 0);
      busWrite(ADDR_CTRL, 32'h1);
      expectState("t4.badenable", 0, 0, 0, 0, 0, 1);
      busWrite(ADDR_CTRL, 32'h4);
      busWrite(ADDR_KICK, 32'h55);
      busWrite(4'h5, 32'hFFFF_FFFF);
      expectState("idle.ignored", 0, 0, 0, 0, 0, 0);
      busWrite(ADDR_INTERVAL, 32'd3);
      busWrite(ADDR_CTRL, 32'h1);
      ticks(1);
      expectState("t5.run2", 1, 1, 2, 0, 0, 0);
      applyStimulus(1'b1, ADDR_CTRL, 32'h2, 1'b1, 1'b0);
      expectState("t5.diskick", 0, 1, 0, 0, 0, 0);

      $display("[TB] reset mid-operation");
      busWrite(ADDR_INTERVAL, 32'd2);
      busWrite(ADDR_CTRL, 32'h1);
      ticks(2);
      expectState("t6.warn", 1, 1, WARN_TICKS, 1, 0, 0);
      pulseReset();
      expectState("t6.rstwarn", 0, 0, 0, 0, 0, 0);
      busWrite(ADDR_INTERVAL, 32'd1);
      busWrite(ADDR_CTRL, 32'h1);
      ticks(1 + WARN_TICKS);
      expectState("t6.expired", 1, 1, 0, 0, 1, 0);
      pulseReset();
      expectState("t6.rstexp", 0, 0, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
      $finish;
   end

endmodule
